// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive-side host controller.
package uart_pkg;

  localparam int unsigned CFG_ADDR    = 'h000;
  localparam int unsigned BAUD_ADDR   = 'h008;
  localparam int unsigned STATUS_ADDR = 'h00C;
  localparam int unsigned DATA_ADDR   = 'h010;
  localparam int unsigned IRQ_EN_ADDR = 'h014;

  localparam int unsigned CFG_DBITS_LSB = 0;
  localparam int unsigned CFG_STOP_BIT  = 2;
  localparam int unsigned CFG_PEN_BIT   = 3;
  localparam int unsigned CFG_PTYPE_BIT = 4;
  localparam int unsigned CFG_EN_BIT    = 5;

  localparam logic [11:0] RX_ACK_ADDR = 12'h004;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received frames as {parity_err, data}.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  assign count   = wptr_q - rptr_q;
  assign empty   = (count == '0);
  assign full    = (count == PTR_W'(DEPTH));
  assign rdata   = mem_q[rptr_q[PTR_W-2:0]];
  // A pop frees a slot on the same edge, so a push into a full FIFO is legal then.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[PTR_W-2:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Host controller for the UART receiver: baud tick, frame format, RX FIFO drain and
// acknowledge handshake, CPU-visible registers and a level interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  output logic              irq,
  output logic              tick,
  output logic [1:0]        data_bit_num,
  output logic              stop_bit_num,
  output logic              parity_en,
  output logic              parity_type,
  output logic              rx_rd_en,
  output logic [ADDR_W-1:0] rx_raddr,
  input  logic              rx_done,
  input  logic              rx_parity_err,
  input  logic [7:0]        rx_data
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t      state_q, state_d;
  logic [5:0]       cfg_q, cfg_d;
  logic [DIV_W-1:0] baud_q, cnt_q, cnt_d;
  logic             overrun_q, overrun_d, parity_q, parity_d;
  logic [2:0]       irq_en_q;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_cfg, wr_baud, wr_status, wr_irq_en, rd_data;
  logic             rx_enable, capture, drop;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [8:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:DIV_W];

  assign wr_cfg    = wr_en && (waddr == ADDR_W'(CFG_ADDR));
  assign wr_baud   = wr_en && (waddr == ADDR_W'(BAUD_ADDR));
  assign wr_status = wr_en && (waddr == ADDR_W'(STATUS_ADDR));
  assign wr_irq_en = wr_en && (waddr == ADDR_W'(IRQ_EN_ADDR));
  assign rd_data   = rd_en && (raddr == ADDR_W'(DATA_ADDR));

  assign rx_enable    = cfg_q[CFG_EN_BIT];
  assign data_bit_num = cfg_q[CFG_DBITS_LSB +: 2];
  assign stop_bit_num = cfg_q[CFG_STOP_BIT];
  assign parity_en    = cfg_q[CFG_PEN_BIT];
  assign parity_type  = cfg_q[CFG_PTYPE_BIT];
  assign tick         = rx_enable && (cnt_q == baud_q);
  assign rdata        = rdata_q;
  assign irq          = irq_q;

  assign fifo_pop  = rd_data && !fifo_empty;
  assign fifo_push = capture && (!fifo_full || fifo_pop);
  assign drop      = capture && fifo_full && !fifo_pop;

  uart_rx_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({rx_parity_err, rx_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Capture only in IDLE: the receiver holds rx_done until acked, so WAIT_CLR
  // guarantees a frame is never taken twice.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    rx_rd_en = 1'b0;
    rx_raddr = '0;
    unique case (state_q)
      IDLE: begin
        if (rx_done) begin
          capture = rx_enable;
          state_d = ACK;
        end
      end
      ACK: begin
        rx_rd_en = 1'b1;
        rx_raddr = ADDR_W'(RX_ACK_ADDR);
        state_d  = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!rx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_d = cfg_q;
    if (wr_cfg) begin
      cfg_d[CFG_EN_BIT] = wdata[CFG_EN_BIT];
      if (!rx_enable) cfg_d[4:0] = wdata[4:0];
    end

    if (!rx_enable || wr_baud) cnt_d = '0;
    else if (cnt_q == baud_q)  cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;

    // Set events are applied after the W1C clear so they win on a collision.
    overrun_d = overrun_q;
    parity_d  = parity_q;
    if (wr_status) begin
      if (wdata[2]) overrun_d = 1'b0;
      if (wdata[3]) parity_d  = 1'b0;
    end
    if (drop)                     overrun_d = 1'b1;
    if (capture && rx_parity_err) parity_d  = 1'b1;

    irq_d = |(irq_en_q & {parity_q, overrun_q, ~fifo_empty});

    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (raddr)
        ADDR_W'(CFG_ADDR):    rdata_d[5:0] = cfg_q;
        ADDR_W'(BAUD_ADDR):   rdata_d[DIV_W-1:0] = baud_q;
        ADDR_W'(STATUS_ADDR): begin
          rdata_d[15:8] = 8'(fifo_count);
          rdata_d[3:0]  = {parity_q, overrun_q, fifo_full, fifo_empty};
        end
        ADDR_W'(DATA_ADDR):   rdata_d = fifo_empty ? 32'h8000_0000 : {23'b0, fifo_rdata};
        ADDR_W'(IRQ_EN_ADDR): rdata_d[2:0] = irq_en_q;
        default:              rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      baud_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      parity_q  <= 1'b0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      parity_q  <= parity_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      if (wr_baud)   baud_q   <= wdata[DIV_W-1:0];
      if (wr_irq_en) irq_en_q <= wdata[2:0];
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl with a queue-based register/FIFO model and a receiver model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam logic [11:0] A_CFG = 12'h000, A_BAUD = 12'h008, A_STATUS = 12'h00C;
  localparam logic [11:0] A_DATA = 12'h010, A_IRQ = 12'h014;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [11:0] waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq, tick, stop_bit_num, parity_en, parity_type, rx_rd_en;
  logic [1:0]  data_bit_num;
  logic [11:0] rx_raddr;
  logic        rx_done = 1'b0, rx_parity_err = 1'b0;
  logic [7:0]  rx_data = '0;

  uart_rx_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .waddr         (waddr),
    .wdata         (wdata),
    .rd_en         (rd_en),
    .raddr         (raddr),
    .rdata         (rdata),
    .irq           (irq),
    .tick          (tick),
    .data_bit_num  (data_bit_num),
    .stop_bit_num  (stop_bit_num),
    .parity_en     (parity_en),
    .parity_type   (parity_type),
    .rx_rd_en      (rx_rd_en),
    .rx_raddr      (rx_raddr),
    .rx_done       (rx_done),
    .rx_parity_err (rx_parity_err),
    .rx_data       (rx_data)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after the most recent clock edge.
  logic [8:0]  m_q[$];
  logic        m_overrun = 0, m_parity = 0, m_irq = 0, m_ack = 0;
  logic [5:0]  m_cfg = '0;
  logic [15:0] m_baud = '0;
  logic [2:0]  m_irq_en = '0;
  logic [31:0] m_rdata = '0;
  int          m_k = 0;        // edges since the baud counter last restarted
  bit          pending = 0;    // receiver frame raised but not yet taken
  int          low_edges = 0;  // consecutive edges with rx_done low
  int          ack_cnt = 0;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int n = m_q.size();
    case (a)
      A_CFG:    return {26'b0, m_cfg};
      A_BAUD:   return {16'b0, m_baud};
      A_STATUS: return {16'b0, 8'(n), 4'b0, m_parity, m_overrun, n == DEPTH, n == 0};
      A_DATA:   return (n == 0) ? 32'h8000_0000 : {23'b0, m_q[0]};
      A_IRQ:    return {29'b0, m_irq_en};
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_overrun = 0; m_parity = 0; m_irq = 0; m_ack = 0;
    m_cfg = '0; m_baud = '0; m_irq_en = '0; m_rdata = '0; m_k = 0;
    pending = 0; low_edges = 0;
  endtask

  task automatic model_update();
    int n = m_q.size();
    bit en = m_cfg[5];
    bit pop, set_ov = 0, set_par = 0;
    m_irq = |(m_irq_en & {m_parity, m_overrun, n != 0});
    if (rd_en) m_rdata = m_read(raddr);
    pop = rd_en && (raddr == A_DATA) && (n != 0);
    if (pop) void'(m_q.pop_front());
    m_ack = 0;
    if (rx_done && pending) begin
      pending = 0;
      m_ack = 1;
      if (en) begin
        if (n == DEPTH && !pop) set_ov = 1;
        else m_q.push_back({rx_parity_err, rx_data});
        set_par = rx_parity_err;
      end
    end
    if (wr_en && waddr == A_STATUS) begin
      if (wdata[2]) m_overrun = 0;
      if (wdata[3]) m_parity = 0;
    end
    if (set_ov) m_overrun = 1;
    if (set_par) m_parity = 1;
    if (wr_en && waddr == A_CFG) m_cfg = en ? {wdata[5], m_cfg[4:0]} : wdata[5:0];
    if (wr_en && waddr == A_BAUD) m_baud = wdata[15:0];
    if (wr_en && waddr == A_IRQ) m_irq_en = wdata[2:0];
    if (!en || (wr_en && waddr == A_BAUD)) m_k = 0;
    else m_k++;
    low_edges = rx_done ? 0 : low_edges + 1;
  endtask

  // Per-cycle compare against the model, half a cycle after each edge.
  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check("rdata", rdata, m_rdata);
      check("irq", 32'(irq), 32'(m_irq));
      check("tick", 32'(tick),
            32'(m_cfg[5] && ((m_k % (int'(m_baud) + 1)) == int'(m_baud))));
      check("format", 32'({parity_type, parity_en, stop_bit_num, data_bit_num}),
            32'(m_cfg[4:0]));
      check("rx_rd_en", 32'(rx_rd_en), 32'(m_ack));
      check("rx_raddr", 32'(rx_raddr), m_ack ? 32'h004 : 32'h000);
    end
  end

  // Receiver model: holds rx_done until acked, then releases after a hold time.
  int bfm_st = 0, bfm_hold = 0, bfm_wait = 0;
  bit auto_frames = 0;

  task automatic start_frame(input logic [7:0] d, input logic e, input int hold);
    rx_done = 1; rx_data = d; rx_parity_err = e;
    pending = 1; bfm_st = 1; bfm_hold = hold; bfm_wait = 0;
  endtask

  task automatic bfm_update();
    case (bfm_st)
      0: if (auto_frames && low_edges > 0 && $urandom_range(0, 3) == 0)
           start_frame(8'($urandom), 1'($urandom), $urandom_range(0, 3));
      1: begin
        rx_parity_err = 1'($urandom);
        if (rx_rd_en) bfm_st = 2;
        else if (++bfm_wait > 10) begin
          checks++; errors++;
          $display("FAIL ack_timeout: got no rx_rd_en, expected one within 10 cycles at %0t", $time);
          rx_done = 0; pending = 0; bfm_st = 0;
        end
      end
      default: if (bfm_hold == 0) begin
        rx_done = 0; bfm_st = 0;
      end else bfm_hold--;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (rx_rd_en) ack_cnt++;
    bfm_update();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1; waddr = a; wdata = d;
    step();
    wr_en = 0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    rd_en = 1; raddr = a;
    step();
    rd_en = 0;
    v = rdata;
  endtask

  task automatic frame(input logic [7:0] d, input logic e, input int hold);
    start_frame(d, e, hold);
    for (int i = 0; i < 40 && bfm_st != 0; i++) step();
    step();
  endtask

  task automatic drain();
    logic [31:0] v;
    for (int i = 0; i < DEPTH + 2; i++) begin
      rd(A_DATA, v);
      if (v == 32'h8000_0000) break;
    end
  endtask

  logic [11:0] addrs [8] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'hFFC};

  initial begin
    logic [31:0] v;
    int n, b2b, acks0;
    bit prev;

    #1 rst_n = 0;
    #2;
    check("reset_rdata", rdata, 32'h0);
    check("reset_outs", 32'({irq, tick, rx_rd_en, rx_raddr}), 32'h0);
    #19 rst_n = 1;
    chk_on = 1;
    step();

    // Baud tick period D+1 while enabled, silent when disabled.
    wr(A_BAUD, 32'd3);
    wr(A_CFG, 32'h23);
    n = 0; b2b = 0; prev = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      n += int'(tick);
      if (tick && prev) b2b++;
      prev = tick;
    end
    check("t1_tick_count", n, 4);
    check("t1_tick_width", b2b, 0);
    wr(A_CFG, 32'h03);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n += int'(tick);
    end
    check("t1_tick_disabled", n, 0);

    // Single frame: one push, one ack.
    wr(A_CFG, 32'h23);
    acks0 = ack_cnt;
    frame(8'hA5, 1'b0, 4);
    check("t2_ack_pulses", ack_cnt - acks0, 1);
    rd(A_STATUS, v);
    check("t2_status", v, 32'h0000_0100);
    rd(A_DATA, v);
    check("t2_data", v, 32'h0000_00A5);
    rd(A_STATUS, v);
    check("t2_empty", v, 32'h0000_0001);

    // Overflow: 17 frames into 16 slots.
    acks0 = ack_cnt;
    for (int i = 0; i < 17; i++) frame(8'(i), 1'b0, $urandom_range(0, 2));
    check("t3_ack_pulses", ack_cnt - acks0, 17);
    rd(A_STATUS, v);
    check("t3_status", v, 32'h0000_1006);

    // Full FIFO: pop and capture on the same edge.
    wr(A_STATUS, 32'h4);
    start_frame(8'hEE, 1'b0, 1);
    rd(A_DATA, v);
    check("t5_oldest", v, 32'h0000_0000);
    for (int i = 0; i < 20 && bfm_st != 0; i++) step();
    step();
    rd(A_STATUS, v);
    check("t5_status", v, 32'h0000_1002);
    drain();

    // Parity error, sticky flag and interrupt.
    wr(A_IRQ, 32'h4);
    frame(8'h3C, 1'b1, 0);
    rd(A_STATUS, v);
    check("t4_status", v, 32'h0000_0108);
    check("t4_irq_set", 32'(irq), 32'h1);
    rd(A_DATA, v);
    check("t4_data", v, 32'h0000_013C);
    wr(A_STATUS, 32'h8);
    check("t4_irq_lag", 32'(irq), 32'h1);
    step();
    check("t4_irq_clr", 32'(irq), 32'h0);

    // Format locked while enabled; empty read pattern.
    wr(A_CFG, 32'h3F);
    rd(A_CFG, v);
    check("t6_cfg", v, 32'h0000_0023);
    check("t6_fmt", 32'({data_bit_num, stop_bit_num, parity_en, parity_type}), 32'h18);
    rd(A_DATA, v);
    check("t6_empty_read", v, 32'h8000_0000);

    // Reset in the middle of the acknowledge.
    start_frame(8'h55, 1'b0, 3);
    step();
    check("t6_in_ack", 32'(rx_rd_en), 32'h1);
    rst_n = 0;
    #1;
    check("t6_rst_rdata", rdata, 32'h0);
    check("t6_rst_outs", 32'({irq, tick, rx_rd_en, rx_raddr, data_bit_num, stop_bit_num,
                              parity_en, parity_type}), 32'h0);
    rx_done = 0; bfm_st = 0;
    model_reset();
    #1 rst_n = 1;
    step();

    // Randomized traffic against the model.
    wr(A_CFG, 32'h20);
    auto_frames = 1;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0: wr(A_CFG, {26'b0, ($urandom_range(0, 3) != 0), 5'($urandom)});
        1: wr(A_BAUD, $urandom_range(0, 5));
        2: wr(A_IRQ, $urandom);
        3: wr(A_STATUS, $urandom_range(0, 15));
        4: begin
          wr_en = 1; waddr = addrs[$urandom_range(0, 7)]; wdata = $urandom;
          if (waddr == A_BAUD) wdata = $urandom_range(0, 5);
          rd_en = 1; raddr = addrs[$urandom_range(0, 7)];
          step();
          wr_en = 0; rd_en = 0;
        end
        5, 6: rd(addrs[$urandom_range(0, 7)], v);
        7: rd(A_DATA, v);
        default: step();
      endcase
    end
    auto_frames = 0;
    for (int i = 0; i < 50 && bfm_st != 0; i++) step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
